// File: rtl/addsub_accum.sv
// addsub_accum: extends each add/sub result, accumulates BURST of them into one signed sum and
// queues completed (or flushed partial) sums in a small output FIFO. Option: ADDSUB_ACCUM_SAT_EN.
module addsub_accum #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 12,
  parameter int BURST      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_op,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [$clog2(BURST+1)-1:0] out_beats,
  output logic                       out_partial,
  output logic                       out_ovf,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(BURST + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = ACC_W + CW + 2;

  // Handshake: a beat transfers on posedge when in_valid && in_ready; a sum leaves on posedge when
  // out_valid && out_ready; out_* stay stable while out_valid && !out_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ACC_W-1:0] acc, ext, raw_sum, acc_next;
  logic [CW-1:0]    cnt, cnt_inc;
  logic             ovf_acc, ovf_now;
  logic             fire, done, fifo_full;
  logic             push_full, push_flush, push, pop;
  logic [EW-1:0]    push_data;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_count;

  // Add results are unsigned magnitudes; subtract results are signed differences.
  assign ext = in_op ? {{(ACC_W-DATA_W){1'b0}}, in_result}
                     : {{(ACC_W-DATA_W){in_result[DATA_W-1]}}, in_result};
  assign raw_sum = acc + ext;
  assign ovf_now = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef ADDSUB_ACCUM_SAT_EN
  always_comb begin
    acc_next = raw_sum;
    if (ovf_now)
      acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_next = raw_sum;
`endif

  assign cnt_inc   = cnt + 1'b1;
  assign fifo_full = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fire      = in_valid && in_ready;
  assign done      = fire && (cnt_inc == CW'(BURST));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire) state_next = ACCUM;
      ACCUM: begin
        if (done)       state_next = IDLE;
        else if (clear) state_next = FLUSH;
      end
      FLUSH:   if (!fifo_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = rst_n && (state != FLUSH) && !fifo_full;
    push_full  = done;
    push_flush = (state == FLUSH) && !fifo_full;
  end

  assign push      = push_full || push_flush;
  assign push_data = push_full ? {acc_next, CW'(BURST), 1'b0, ovf_acc | ovf_now}
                               : {acc, cnt, 1'b1, ovf_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (push) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (fire) begin
      acc     <= acc_next;
      cnt     <= cnt_inc;
      ovf_acc <= ovf_acc | ovf_now;
    end
  end

  // Output FIFO; a push only happens with space left, so full+push never occurs.
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);
  assign {out_sum, out_beats, out_partial, out_ovf} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// tb_addsub_accum: scoreboard bench for addsub_accum (default 12-bit build plus a 9-bit instance).
module tb_addsub_accum;

  localparam int EXP_W = 12 + 3 + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_op = 1'b1, clear = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_result = '0;
  logic        in_ready, out_valid, out_partial, out_ovf;
  logic [11:0] out_sum;
  logic [2:0]  out_beats;
  logic [1:0]  dbg_state;

  logic        p9_valid = 1'b0, p9_op = 1'b1, p9_clear = 1'b0, p9_out_ready = 1'b1;
  logic [7:0]  p9_result = '0;
  logic        p9_in_ready, p9_out_valid, p9_partial, p9_ovf;
  logic [8:0]  p9_sum;
  logic [2:0]  p9_beats;
  logic [1:0]  p9_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  int m_acc = 0, m_cnt = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  addsub_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_op(in_op), .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_beats(out_beats), .out_partial(out_partial), .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  addsub_accum #(.ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(p9_valid), .in_ready(p9_in_ready), .in_result(p9_result),
    .in_op(p9_op), .clear(p9_clear), .out_valid(p9_out_valid), .out_ready(p9_out_ready),
    .out_sum(p9_sum), .out_beats(p9_beats), .out_partial(p9_partial), .out_ovf(p9_ovf),
    .dbg_state(p9_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference accumulate on plain integers, range-checked against a w-bit signed accumulator.
  function automatic int model_add(input int acc, input int ext, input int w, output bit ovf);
    int s, mx, mn;
    s  = acc + ext;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    ovf = (s > mx) || (s < mn);
`ifdef ADDSUB_ACCUM_SAT_EN
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
`else
    if (s > mx) s = s - (1 << w);
    else if (s < mn) s = s + (1 << w);
`endif
    return s;
  endfunction

  function automatic int ext_of(input int v, input bit op);
    return op ? v : ((v >= 128) ? v - 256 : v);
  endfunction

  function automatic logic [EXP_W-1:0] pack(input int acc, input int beats, input bit part,
                                            input bit ovf);
    logic [31:0] a, b;
    a = acc;
    b = beats;
    return {a[11:0], b[2:0], part, ovf};
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Drive one beat (optionally with clear in the accepting cycle); returns 1 time unit after the edge.
  task automatic send_beat(input int v, input bit op, input bit clr);
    int  waited, cnt_before;
    bit  o;
    in_result = v[7:0];
    in_op     = op;
    in_valid  = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (waited > 2) begin
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
    clear = clr;
    @(posedge clk);
    cnt_before = m_cnt;
    m_acc = model_add(m_acc, ext_of(v, op), 12, o);
    m_ovf = m_ovf | o;
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back(pack(m_acc, 4, 1'b0, m_ovf));
      model_reset();
    end else if (clr && cnt_before > 0) begin
      exp_q.push_back(pack(m_acc, m_cnt, 1'b1, m_ovf));
      model_reset();
    end
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    if (m_cnt > 0) begin
      exp_q.push_back(pack(m_acc, m_cnt, 1'b1, m_ovf));
      model_reset();
    end
    #1 clear = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    out_ready = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    if (k == 100) check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sum", {20'd0, out_sum}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", {20'd0, out_sum}, {20'd0, mon_e[16:5]});
        check("beats", {29'd0, out_beats}, {29'd0, mon_e[4:2]});
        check("partial", {31'd0, out_partial}, {31'd0, mon_e[1]});
        check("ovf", {31'd0, out_ovf}, {31'd0, mon_e[0]});
        n_pop++;
      end
    end
  end

  initial begin
    int  m9, pop0;
    bit  o, o9;
    logic [31:0] m9v;

    // reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_flags", {out_beats, out_partial, out_ovf}, 0);
    check("rst_state", dbg_state, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_in_ready", in_ready, 1);

    // test 1: add 1,2,3,4
    for (int i = 1; i <= 4; i++) send_beat(i, 1'b1, 1'b0);
    check("t1_latency", out_valid, 1);
    check("t1_sum", out_sum, 10);
    wait_drain("t1_drain");

    // test 2: subtract results of -1 x4
    for (int i = 0; i < 4; i++) send_beat(8'hFF, 1'b0, 1'b0);
    check("t2_sum", out_sum, 12'hFFC);
    wait_drain("t2_drain");

    // test 3: 9-bit accumulator, add 255 x4
    m9 = 0;
    o9 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p9_valid  = 1'b1;
      p9_result = 8'hFF;
      p9_op     = 1'b1;
      @(negedge clk);
      check("t3_ready", p9_in_ready, 1);
      @(posedge clk);
      m9 = model_add(m9, 255, 9, o);
      o9 = o9 | o;
      #1;
    end
    p9_valid = 1'b0;
    m9v = m9;
    check("t3_valid", p9_out_valid, 1);
    check("t3_sum_model", p9_sum, {23'd0, m9v[8:0]});
`ifdef ADDSUB_ACCUM_SAT_EN
    check("t3_sum", p9_sum, 9'h0FF);
`else
    check("t3_sum", p9_sum, 9'h1FC);
`endif
    check("t3_ovf", p9_ovf, 1);
    check("t3_ovf_model", p9_ovf, o9);
    check("t3_beats", p9_beats, 4);

    // test 4: backpressure with full FIFO
    out_ready = 1'b0;
    pop0 = n_pop;
    for (int i = 0; i < 8; i++) send_beat(1, 1'b1, 1'b0);
    check("t4_full_blocks", in_ready, 0);
    check("t4_head", out_sum, 4);
    repeat (2) @(posedge clk);
    #1 check("t4_hold_sum", out_sum, 4);
    check("t4_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(1, 1'b1, 1'b0);
    wait_drain("t4_drain");
    check("t4_pops", n_pop - pop0, 3);

    // test 5: partial flush, then clear in IDLE
    send_beat(5, 1'b1, 1'b0);
    send_beat(6, 1'b1, 1'b0);
    do_clear();
    check("t5_flush_state", dbg_state, 2);
    check("t5_flush_ready", in_ready, 0);
    wait_drain("t5_drain");
    pop0 = n_pop;
    do_clear();
    repeat (3) @(posedge clk);
    #1 check("t5_idle_clear", out_valid, 0);
    check("t5_idle_pops", n_pop - pop0, 0);

    // beat completing the burst together with clear: normal sum, no flush
    for (int i = 0; i < 3; i++) send_beat(2, 1'b1, 1'b0);
    send_beat(2, 1'b1, 1'b1);
    check("t5b_state", dbg_state, 0);
    wait_drain("t5b_drain");

    // randomized beats with backpressure and occasional clears
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) do_clear();
      else send_beat($urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0);
    end
    do_clear();
    wait_drain("rand_drain");

    // test 6: reset mid-burst with one sum queued
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_sum", out_sum, 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(1, 1'b1, 1'b0);
    check("t6_sum", out_sum, 4);
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
